// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed multi-digit 7-segment driver for the stopwatch display.
// A packed hex word and a decimal-point mask are captured into shadow
// registers on iLOAD; the scanner then walks one digit per slot across a
// shared active-low segment bus with active-low digit enables.
//
// Features: anti-ghosting guard window at the start of each slot,
// leading-zero blanking, per-digit decimal points, frame pulse, and optional
// per-digit blink.
//
// Optional feature macro: SEG_BLINK_EN
//   defined   -> blink phase toggles every BLINK_FRAMES frames; digits whose
//                iBLINK_MASK bit is set go dark while the phase is 1.
//   undefined -> no blink logic; iBLINK_MASK is ignored.
//
// Ports:
//   iCLK        system clock, rising edge
//   iRST        synchronous active-high reset
//   iDATA       packed hex digits, digit i in [4i+3:4i]
//   iDP_MASK    decimal point per digit, 1 = lit
//   iLOAD       capture strobe for iDATA / iDP_MASK
//   iBLANK_LZ   leading-zero blanking enable (live)
//   iBLINK_MASK digits that blink (live)
//   oSEG        active-low segments, bit0 = a .. bit6 = g
//   oDP         active-low decimal point
//   oAN         active-low digit enables, at most one low
//   oFRAME      one-cycle pulse at each frame wrap
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [4*NUM_DIGITS-1:0] iDATA,
    input  logic [NUM_DIGITS-1:0]   iDP_MASK,
    input  logic                    iLOAD,
    input  logic                    iBLANK_LZ,
    input  logic [NUM_DIGITS-1:0]   iBLINK_MASK,
    output logic [6:0]              oSEG,
    output logic                    oDP,
    output logic [NUM_DIGITS-1:0]   oAN,
    output logic                    oFRAME
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           prescalerReg;
    logic [IW-1:0]           idxReg;
    logic [4*NUM_DIGITS-1:0] dataShadowReg;
    logic [NUM_DIGITS-1:0]   dpShadowReg;

    logic                    slotEnd;
    logic                    frameWrap;
    logic                    guardDone;
    logic                    lzBlank;
    logic                    blinkNow;

    logic [3:0]              digitVal [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   upperZero;   // digit gi and all above it are 0

    logic [6:0]              segNext;
    logic                    dpNext;
    logic [NUM_DIGITS-1:0]   anNext;

    assign slotEnd   = (prescalerReg == PRE_LAST);
    assign frameWrap = slotEnd && (idxReg == IDX_LAST);

    // With no guard the digit is enabled for the whole slot; a separate
    // branch avoids a degenerate ">= 0" compare.
    generate
        if (GUARD == 0) begin : gNoGuard
            assign guardDone = 1'b1;
        end else begin : gGuard
            assign guardDone = (prescalerReg >= PW'(GUARD));
        end
    endgenerate

    // Per-digit views of the shadow word. upperZero is computed from a
    // constant slice per digit rather than a chained AND, so there is no
    // combinational path through the vector itself.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : gDigit
            assign digitVal[gi]  = dataShadowReg[4*gi +: 4];
            assign upperZero[gi] = (dataShadowReg[4*NUM_DIGITS-1:4*gi] == '0);
        end
    endgenerate

    // Digit 0 always shows, so an all-zero word still displays "0".
    assign lzBlank = iBLANK_LZ && (idxReg != '0) && upperZero[idxReg];

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frameCntReg;
    logic          blinkPhaseReg;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            frameCntReg   <= '0;
            blinkPhaseReg <= 1'b0;
        end else if (frameWrap) begin
            if (frameCntReg == FRAME_LAST) begin
                frameCntReg   <= '0;
                blinkPhaseReg <= ~blinkPhaseReg;
            end else begin
                frameCntReg <= frameCntReg + FW'(1);
            end
        end
    end

    assign blinkNow = blinkPhaseReg && iBLINK_MASK[idxReg];
`else
    logic unusedBlinkMask;
    assign unusedBlinkMask = ^iBLINK_MASK;
    assign blinkNow        = 1'b0;
`endif

    function automatic logic [6:0] segDecode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Segment / DP values are driven for the whole slot, including the guard
    // window, so they have settled before the enable turns on.
    always_comb begin
        segNext = segDecode(digitVal[idxReg]);
        dpNext  = ~dpShadowReg[idxReg];
        anNext  = '1;
        if (lzBlank) begin
            segNext = 7'h7F;   // DP still follows the mask
        end
        if (blinkNow) begin
            segNext = 7'h7F;
            dpNext  = 1'b1;
        end
        if (guardDone) begin
            anNext = ~(NUM_DIGITS'(1) << idxReg);
        end
    end

    // Scan counters and shadows. A load coinciding with a slot advance lands
    // in the same edge, so the new slot is rendered from the new data.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            prescalerReg  <= '0;
            idxReg        <= '0;
            dataShadowReg <= '0;
            dpShadowReg   <= '0;
        end else begin
            if (slotEnd) begin
                prescalerReg <= '0;
                idxReg       <= (idxReg == IDX_LAST) ? '0 : idxReg + IW'(1);
            end else begin
                prescalerReg <= prescalerReg + PW'(1);
            end
            if (iLOAD) begin
                dataShadowReg <= iDATA;
                dpShadowReg   <= iDP_MASK;
            end
        end
    end

    // Registered outputs: one cycle behind the counter/shadow state.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oSEG   <= 7'h7F;
            oDP    <= 1'b1;
            oAN    <= '1;
            oFRAME <= 1'b0;
        end else begin
            oSEG   <= segNext;
            oDP    <= dpNext;
            oAN    <= anNext;
            oFRAME <= frameWrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Scoreboard bench for seg_scan_driver (NUM_DIGITS=4, SCAN_DIV=8, GUARD=2,
// BLINK_FRAMES=2). The driver pushes the expected output word for every
// cycle, computed from elapsed time since reset with plain arithmetic; a
// separate monitor pops and compares the DUT outputs each cycle.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int ND        = 4;
    localparam int SD        = 8;
    localparam int GD        = 2;
    localparam int BF        = 2;
    localparam int FRAME_LEN = ND * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dpMask;
    logic        load;
    logic        blankLz;
    logic [3:0]  blinkMask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .GUARD       (GD),
        .BLINK_FRAMES(BF)
    ) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iDATA      (data),
        .iDP_MASK   (dpMask),
        .iLOAD      (load),
        .iBLANK_LZ  (blankLz),
        .iBLINK_MASK(blinkMask),
        .oSEG       (seg),
        .oDP        (dp),
        .oAN        (an),
        .oFRAME     (frame)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       frame;
    } out_t;

    out_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: cycles elapsed since reset plus the shadows.
    int          c     = 0;
    logic [15:0] mData = '0;
    logic [3:0]  mDp   = '0;

    logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};

    // Expected outputs for the cycle after the coming edge.
    function automatic out_t predict();
        out_t       e;
        int         pre;
        int         idx;
        bit         phase;
        bit         lz;
        bit         blink;
        logic [3:0] dig;
        if (rst) begin
            e.seg   = 7'h7F;
            e.dp    = 1'b1;
            e.an    = 4'hF;
            e.frame = 1'b0;
            return e;
        end
        pre = c % SD;
        idx = (c / SD) % ND;
`ifdef SEG_BLINK_EN
        phase = (((c / FRAME_LEN) / BF) % 2) == 1;
`else
        phase = 1'b0;
`endif
        dig     = mData[4*idx +: 4];
        lz      = blankLz && (idx > 0) && ((mData >> (4*idx)) == 16'h0);
        blink   = phase && blinkMask[idx];
        e.seg   = (lz || blink) ? 7'h7F : segTab[dig];
        e.dp    = blink ? 1'b1 : ~mDp[idx];
        e.an    = (pre >= GD) ? ~(4'b0001 << idx) : 4'hF;
        e.frame = ((c + 1) % FRAME_LEN) == 0;
        return e;
    endfunction

    // One clock: record the expectation, advance the model across the edge,
    // then return at the falling edge ready for the next input drive.
    task automatic cycle();
        expQ.push_back(predict());
        if (rst) begin
            c     = 0;
            mData = '0;
            mDp   = '0;
        end else begin
            c++;
            if (load) begin
                mData = data;
                mDp   = dpMask;
            end
        end
        @(negedge clk);
    endtask

    task automatic doLoad(input logic [15:0] d, input logic [3:0] m);
        data   = d;
        dpMask = m;
        load   = 1'b1;
        $display("load  t=%0t data=%h dp=%b lz=%b blink=%b slotpos=%0d",
                 $time, d, m, blankLz, blinkMask, c % FRAME_LEN);
        cycle();
        load = 1'b0;
    endtask

    // Monitor: compares every cycle, one FAIL line per mismatching cycle.
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t: no expected entry queued", $time);
            end else begin
                e = expQ.pop_front();
                if ({seg, dp, an, frame} !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t: got seg=%h dp=%b an=%h frame=%b, need seg=%h dp=%b an=%h frame=%b",
                             $time, seg, dp, an, frame, e.seg, e.dp, e.an, e.frame);
                end
            end
        end
    end

    initial begin
        logic [15:0] r;
        rst       = 1'b1;
        load      = 1'b0;
        data      = '0;
        dpMask    = '0;
        blankLz   = 1'b0;
        blinkMask = '0;

        // Reset held three cycles, then release and idle into the first slot.
        repeat (3) cycle();
        rst = 1'b0;
        repeat (4) cycle();

        // Full scan with digit 0 blinking across several frames.
        blinkMask = 4'b0001;
        doLoad(16'h1A3F, 4'b0100);
        repeat (5 * FRAME_LEN) cycle();
        blinkMask = 4'b0000;

        // Leading-zero blanking, including the all-zero word.
        blankLz = 1'b1;
        doLoad(16'h0005, 4'b0010);
        repeat (FRAME_LEN + 4) cycle();
        doLoad(16'h0000, 4'b0000);
        repeat (FRAME_LEN + 4) cycle();
        blankLz = 1'b0;

        // Load during digit 0's enabled window.
        for (int k = 0; k < 2 * FRAME_LEN && (c % FRAME_LEN) != 3; k++) cycle();
        doLoad(16'h0009, 4'b0000);
        repeat (SD) cycle();

        // Load coinciding with a slot advance.
        for (int k = 0; k < 2 * SD && (c % SD) != SD - 1; k++) cycle();
        doLoad(16'h4E7C, 4'b1001);
        repeat (FRAME_LEN) cycle();

        // Reset while digit 2 is enabled.
        for (int k = 0; k < 2 * FRAME_LEN && (c % FRAME_LEN) != 2 * SD + 4; k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        doLoad(16'h8B2D, 4'b0110);
        repeat (FRAME_LEN + 4) cycle();

        // Randomized traffic.
        for (int k = 0; k < 700; k++) begin
            if ($urandom_range(0, 39) == 0) blankLz = ~blankLz;
            if ($urandom_range(0, 39) == 0) blinkMask = 4'($urandom);
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end else if ($urandom_range(0, 11) == 0) begin
                r = 16'($urandom);
                if ($urandom_range(0, 1) == 1) r = r >> (4 * $urandom_range(1, 4));
                doLoad(r, 4'($urandom));
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed multi-digit 7-segment display driver for the stopwatch display path. It captures a packed hex word into a shadow register on a load strobe and scans one digit at a time across a shared active-low segment bus with active-low digit enables. It adds anti-ghosting guard time, leading-zero blanking, per-digit decimal points, a frame pulse and optional per-digit blink.

## Interface
- NUM_DIGITS, 4: number of scanned digits, 1..8; digit 0 is least significant.
- SCAN_DIV, 50000: clock cycles per digit slot; must be greater than GUARD.
- GUARD, 500: cycles at the start of each slot with all digit enables off; 0 or more.
- BLINK_FRAMES, 64: frames per blink half-period; 1 or more. Used only with SEG_BLINK_EN.
- iCLK  in  1  system clock; every register updates on its rising edge.
- iRST  in  1  reset: one clock, synchronous, active-high.
- iDATA  in  4*NUM_DIGITS  packed hex digits; bits [4i+3:4i] hold digit i.
- iDP_MASK  in  NUM_DIGITS  decimal point enable per digit; 1 = lit.
- iLOAD  in  1  capture strobe for iDATA and iDP_MASK.
- iBLANK_LZ  in  1  leading-zero blanking enable; sampled live every cycle.
- iBLINK_MASK  in  NUM_DIGITS  digits that blink; sampled live every cycle.
- oSEG  out  7  active-low segments, bit0 = a through bit6 = g.
- oDP  out  1  active-low decimal point.
- oAN  out  NUM_DIGITS  active-low digit enables; at most one bit low at any time.
- oFRAME  out  1  one-cycle pulse at each frame wrap.

## Operation
- **Shadow registers.** iLOAD=1 at an edge captures iDATA and iDP_MASK into the shadow registers. When iLOAD is 0, the shadows hold. The display always reads the shadows, never the live inputs.
- **Scan counters.**
  - Prescaler counts 0..SCAN_DIV-1.
  - When the prescaler equals SCAN_DIV-1: it returns to 0 and the digit index idx advances.
  - idx wraps from NUM_DIGITS-1 to 0. On that wrap edge, oFRAME goes to 1 for exactly one cycle.
- **Segment encoding** (oSEG, active-low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30
  - 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h18, A=7'h08, b=7'h03
  - C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- **Leading-zero blanking.**
  - Applies only when iBLANK_LZ=1.
  - Digit i>0 is blanked when digit i and every more significant digit are 0.
  - Digit 0 is never blanked.
  - A blanked digit drives oSEG=7'h7F; its DP still follows the shadow mask.
- **Blink.** When blink is active for a digit (see Configuration), it drives oSEG=7'h7F and oDP=1.
- **Digit enable.** oAN[idx]=0 only while prescaler ≥ GUARD. During the guard window all oAN bits are 1; oSEG and oDP already carry the new digit's value.

## Timing
- **Reset values:** oAN all 1, oSEG=7'h7F, oDP=1, oFRAME=0. Prescaler, idx, shadows and blink phase all clear to 0.
- **Output latency:** oSEG, oDP, oAN and oFRAME are registered. Outputs in cycle n+1 reflect the idx, prescaler and shadow values of cycle n.
- **Load latency:** iLOAD in cycle n updates the shadows at edge n. The new glyph appears on outputs in cycle n+2 if the current slot is still enabled.
- **Simultaneous load and slot advance:** the new slot uses the newly loaded data.
- **Reset mid-scan:** the next edge returns to the reset state. Scanning restarts at digit 0, beginning with a guard window.
- **Frame period:** NUM_DIGITS*SCAN_DIV cycles. oFRAME pulses once per frame.
- **Unlit time:** with GUARD=0, a digit is never unlit between slots.

## Configuration
- **SEG_BLINK_EN defined:**
  - A frame counter toggles the blink phase every BLINK_FRAMES frames.
  - While the phase is 1, digits whose iBLINK_MASK bit is 1 are blanked (segments and DP off).
  - The phase starts at 0 after reset.
- **SEG_BLINK_EN undefined:**
  - The blink counter logic is absent.
  - The iBLINK_MASK port remains but is ignored; no digit ever blinks.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2.
- **Reset values:** hold iRST for 3 cycles -> oAN=4'hF, oSEG=7'h7F, oDP=1, oFRAME=0. First oAN=4'hE appears 3 cycles after release (2-cycle guard plus 1 cycle output latency).
- **Full scan:** load iDATA=16'h1A3F, iDP_MASK=4'b0100 -> per slot oSEG is 7'h0E, 7'h30, 7'h08, 7'h79 on oAN=E, D, B, 7. oDP=0 only on digit 2. oFRAME pulses every 32 cycles.
- **Leading-zero blanking:** iDATA=16'h0005, iBLANK_LZ=1 -> digits 3..1 show oSEG=7'h7F and digit 0 shows 7'h12. With iDATA=16'h0000, digit 0 shows 7'h40.
- **Load in mid-slot:** iLOAD with 16'h0009 during digit 0's enabled window -> oSEG changes from the old glyph to 7'h18 two cycles later; oAN is unchanged.
- **Mid-scan reset:** assert iRST while oAN=4'hB -> next cycle all outputs are at reset values and scanning restarts at digit 0.
- **Blink (SEG_BLINK_EN defined):** iBLINK_MASK=4'b0001 -> digit 0 is lit for frames 0-1, blank for frames 2-3, then lit again. With the macro undefined, digit 0 is always lit.
